// File: rtl/ipif_pkg.sv
// Shared definitions for the IPIF register path: state encoding, the
// counter-width helper and the default access timeout.
package ipif_pkg;

  // Command initiator state encoding.
  localparam logic [1:0] IPIF_ST_IDLE   = 2'd0;
  localparam logic [1:0] IPIF_ST_ACCESS = 2'd1;
  localparam logic [1:0] IPIF_ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IPIF_ST_IDLE,
    ST_ACCESS = IPIF_ST_ACCESS,
    ST_RESP   = IPIF_ST_RESP
  } ipif_state_e;

  // Cycles Bus2IP_CS may stay high without an ack before the access is abandoned.
  localparam int unsigned IPIF_TIMEOUT_DEFAULT = 64;

  // Ceiling log2; also used by the register slave to size its address decode.
  function automatic int unsigned ipif_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ipif_timeout_ctr.sv
// Access timeout counter: cleared when a command is launched, counts while
// the access is open, saturates, and flags the last permitted cycle.
module ipif_timeout_ctr
  import ipif_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = IPIF_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned   CW   = ipif_log2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] MAX  = '1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise increment while enabled until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count reads TIMEOUT_CYCLES-1 during the final cycle CS may stay high.
  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/ipif_cmd_initiator.sv
// IPIF bus master: takes one register command at a time from a valid/ready
// stream, runs a single IPIF access, and returns data/status on a response
// stream. An access ends on the direction-matching ack or on timeout.
//
// Handshakes: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both 1. rsp_valid and all rsp_* fields hold
// steady until that transfer, and cmd_ready stays 0 while a command is open.
module ipif_cmd_initiator
  import ipif_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = IPIF_TIMEOUT_DEFAULT
) (
  input  logic                              Bus2IP_Clk,
  input  logic                              Bus2IP_Resetn,
  // command stream
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_rnw,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     cmd_data,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   cmd_be,
  // response stream
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     rsp_data,
  output logic                              rsp_error,
  output logic                              rsp_timeout,
  // IPIF master side
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     Bus2IP_Addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
  output logic                              Bus2IP_RNW,
  output logic                              Bus2IP_CS,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     IP2Bus_Data,
  input  logic                              IP2Bus_RdAck,
  input  logic                              IP2Bus_WrAck,
  input  logic                              IP2Bus_Error,
  // debug
  output logic [1:0]                        dbg_state_o
);

  ipif_state_e                       state_q;
  logic                              cmd_ready_q;
  logic                              rsp_valid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]     rsp_data_q;
  logic                              rsp_error_q;
  logic                              rsp_timeout_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   be_q;
  logic                              rnw_q;
  logic                              cs_q;

  logic accept;
  logic ack_match;
  logic expire;

  // cmd_ready must read 0 for the whole reset cycle, not only after it.
  assign cmd_ready = cmd_ready_q & Bus2IP_Resetn;
  assign accept    = cmd_valid & cmd_ready_q;
  // Only the ack for the open direction closes the access.
  assign ack_match = rnw_q ? IP2Bus_RdAck : IP2Bus_WrAck;

  ipif_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i    (Bus2IP_Clk),
    .rst_n_i  (Bus2IP_Resetn),
    .clr_i    (accept),
    .en_i     (state_q == ST_ACCESS),
    .expire_o (expire)
  );

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge Bus2IP_Clk) begin
    if (!Bus2IP_Resetn) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      rnw_q         <= 1'b0;
      cs_q          <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_data;
            be_q        <= cmd_be;
            rnw_q       <= cmd_rnw;
            cs_q        <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // A matching ack in the expiry cycle still counts as a normal completion.
          if (ack_match) begin
            rsp_data_q    <= rnw_q ? IP2Bus_Data : '0;
            rsp_error_q   <= IP2Bus_Error;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            cs_q          <= 1'b0;
            state_q       <= ST_RESP;
          end else if (expire) begin
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            cs_q          <= 1'b0;
            state_q       <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Late or duplicate acks arriving here are simply not looked at.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign Bus2IP_Addr = addr_q;
  assign Bus2IP_Data = wdata_q;
  assign Bus2IP_BE   = be_q;
  assign Bus2IP_RNW  = rnw_q;
  assign Bus2IP_CS   = cs_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ipif_cmd_initiator.sv
// Bench for ipif_cmd_initiator: a behavioural register slave (2 WO, 2 RW,
// 2 RO words, registered ack, WO reads never acked), a table of directed
// vectors, hand-written corner sequences and a randomized phase checked
// against an abstract register-map model through an expected queue.
module tb_ipif_cmd_initiator;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 8;
  localparam int EW  = 50; // {cs_len[7:0], lat[7:0], timeout, error, data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            cmd_valid = 1'b0, cmd_rnw = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [DW-1:0]   cmd_data = '0;
  logic [DW/8-1:0] cmd_be = '0;
  logic            cmd_ready;
  logic            rsp_valid, rsp_error, rsp_timeout;
  logic            rsp_ready = 1'b1;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   Bus2IP_Addr;
  logic [DW-1:0]   Bus2IP_Data;
  logic [DW/8-1:0] Bus2IP_BE;
  logic            Bus2IP_RNW, Bus2IP_CS;
  logic [DW-1:0]   IP2Bus_Data;
  logic            IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error;
  logic [1:0]      dbg_state;

  ipif_cmd_initiator #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rnw       (cmd_rnw),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .cmd_be        (cmd_be),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_error     (rsp_error),
    .rsp_timeout   (rsp_timeout),
    .Bus2IP_Addr   (Bus2IP_Addr),
    .Bus2IP_Data   (Bus2IP_Data),
    .Bus2IP_BE     (Bus2IP_BE),
    .Bus2IP_RNW    (Bus2IP_RNW),
    .Bus2IP_CS     (Bus2IP_CS),
    .IP2Bus_Data   (IP2Bus_Data),
    .IP2Bus_RdAck  (IP2Bus_RdAck),
    .IP2Bus_WrAck  (IP2Bus_WrAck),
    .IP2Bus_Error  (IP2Bus_Error),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- behavioural register slave ----------------
  logic [DW-1:0] s_mem [0:3] = '{default: '0}; // WO0, WO1, RW0, RW1
  logic          s_rdack = 1'b0, s_wrack = 1'b0, s_err = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  logic          slave_mute = 1'b0;
  logic          inj_rd = 1'b0, inj_wr = 1'b0, inj_err = 1'b0;
  logic [DW-1:0] inj_data = '0;

  assign IP2Bus_RdAck = s_rdack | inj_rd;
  assign IP2Bus_WrAck = s_wrack | inj_wr;
  assign IP2Bus_Error = s_err | inj_err;
  assign IP2Bus_Data  = s_rdata | inj_data;

  // Slave: one-cycle registered ack per access, WO reads left unanswered.
  always @(posedge clk) begin
    logic oor;
    logic [2:0] idx;
    logic [DW-1:0] m;
    s_rdack <= 1'b0; s_wrack <= 1'b0; s_err <= 1'b0; s_rdata <= '0;
    oor = (Bus2IP_Addr >= 32'h18);
    idx = Bus2IP_Addr[4:2];
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{Bus2IP_BE[b]}};
    if (resetn && Bus2IP_CS && !s_rdack && !s_wrack && !slave_mute) begin
      if (Bus2IP_RNW) begin
        if (oor) begin
          s_rdack <= 1'b1; s_err <= 1'b1;
        end else if (idx >= 3'd2) begin
          s_rdack <= 1'b1;
          s_rdata <= (idx < 3'd4) ? s_mem[idx[1:0]] : (32'hC0DE_0000 | Bus2IP_Addr);
        end
      end else begin
        s_wrack <= 1'b1;
        if (oor || idx >= 3'd4) s_err <= 1'b1;
        else s_mem[idx[1:0]] <= (s_mem[idx[1:0]] & ~m) | (Bus2IP_Data & m);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int nvec = 0, nerr = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  int acc_q[$];
  logic [DW-1:0] mm [0:3] = '{default: '0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input int cs, input int lat, input logic to,
                                             input logic err, input logic [DW-1:0] d);
    return {8'(cs), 8'(lat), to, err, d};
  endfunction

  // Register-map reference: what a command must return, given the map rules.
  function automatic logic [EW-1:0] model(input logic rnw, input logic [AW-1:0] a,
                                          input logic [DW-1:0] d, input logic [3:0] be);
    logic [DW-1:0] mask;
    int idx;
    logic oor;
    oor = (a >= 32'h18);
    idx = int'(a[4:2]);
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{be[b]}};
    if (rnw) begin
      if (oor) return pack_exp(2, 3, 1'b0, 1'b1, '0);
      if (idx < 2) return pack_exp(TMO, TMO + 1, 1'b1, 1'b1, '0);
      if (idx < 4) return pack_exp(2, 3, 1'b0, 1'b0, mm[idx]);
      return pack_exp(2, 3, 1'b0, 1'b0, 32'hC0DE_0000 | a);
    end
    if (oor || idx >= 4) return pack_exp(2, 3, 1'b0, 1'b1, '0);
    mm[idx] = (mm[idx] & ~mask) | (d & mask);
    return pack_exp(2, 3, 1'b0, 1'b0, '0);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  int acc_cyc = 0, cs_run = 0;
  bit cs_prev = 1'b0, rv_prev = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (cmd_valid && cmd_ready) begin
      acc_cyc = cyc;
      acc_q.push_back(cyc);
    end
    if (Bus2IP_CS) begin
      cs_run++;
    end else if (cs_prev) begin
      if (exp_q.size() > 0 && exp_q[0][49:42] != 8'hFF)
        check("cs_high_cycles", 64'(cs_run), 64'(exp_q[0][49:42]));
      cs_run = 0;
    end
    cs_prev = Bus2IP_CS;
    if (rsp_valid && !rv_prev && exp_q.size() > 0 && exp_q[0][41:34] != 8'hFF)
      check("rsp_latency", 64'(cyc - acc_cyc), 64'(exp_q[0][41:34]));
    rv_prev = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(e[31:0]));
        check("rsp_error", 64'(rsp_error), 64'(e[32]));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e[33]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] be, input logic [EW-1:0] e);
    int n;
    n = 0;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_data = d; cmd_be = be;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      check("cmd_accept_wait", 64'(0), 64'(1));
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    cmd_valid = 1'b0;
    while (exp_q.size() != 0 && n < 1000) begin tick(); n++; end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rnw; logic [AW-1:0] addr; logic [DW-1:0] data; logic [3:0] be;
    logic [DW-1:0] e_data; logic e_err; logic e_to; int e_cs; int e_lat;
  } vec_t;
  localparam int NV = 12;
  vec_t vecs [NV];

  bit bp_en = 1'b0;

  initial begin
    vecs[0]  = '{1'b0, 32'h00, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0, 2,   3};
    vecs[1]  = '{1'b0, 32'h08, 32'h12345678, 4'hF, 32'h0,        1'b0, 1'b0, 2,   3};
    vecs[2]  = '{1'b1, 32'h08, 32'h0,        4'hF, 32'h12345678, 1'b0, 1'b0, 2,   3};
    vecs[3]  = '{1'b1, 32'h00, 32'h0,        4'hF, 32'h0,        1'b1, 1'b1, TMO, TMO+1};
    vecs[4]  = '{1'b0, 32'h0C, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 1'b0, 2,   3};
    vecs[5]  = '{1'b1, 32'h0C, 32'h0,        4'hF, 32'h00BB00DD, 1'b0, 1'b0, 2,   3};
    vecs[6]  = '{1'b1, 32'h10, 32'h0,        4'hF, 32'hC0DE0010, 1'b0, 1'b0, 2,   3};
    vecs[7]  = '{1'b0, 32'h14, 32'h55555555, 4'hF, 32'h0,        1'b1, 1'b0, 2,   3};
    vecs[8]  = '{1'b1, 32'h20, 32'h0,        4'hF, 32'h0,        1'b1, 1'b0, 2,   3};
    vecs[9]  = '{1'b0, 32'h04, 32'h11112222, 4'hF, 32'h0,        1'b0, 1'b0, 2,   3};
    vecs[10] = '{1'b1, 32'h04, 32'h0,        4'hF, 32'h0,        1'b1, 1'b1, TMO, TMO+1};
    vecs[11] = '{1'b1, 32'h14, 32'h0,        4'hF, 32'hC0DE0014, 1'b0, 1'b0, 2,   3};

    // Reset state.
    resetn = 1'b0;
    tick(); tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_cs", 64'(Bus2IP_CS), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_error", 64'(rsp_error), 64'(0));
    check("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
    check("rst_addr", 64'(Bus2IP_Addr), 64'(0));
    check("rst_rnw", 64'(Bus2IP_RNW), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    resetn = 1'b1;
    tick();
    check("ready_after_release", 64'(cmd_ready), 64'(1));

    // Directed table, back-to-back with rsp_ready held high.
    for (int i = 0; i < NV; i++) begin
      void'(model(vecs[i].rnw, vecs[i].addr, vecs[i].data, vecs[i].be));
      run_cmd(vecs[i].rnw, vecs[i].addr, vecs[i].data, vecs[i].be,
              pack_exp(vecs[i].e_cs, vecs[i].e_lat, vecs[i].e_to, vecs[i].e_err, vecs[i].e_data));
    end
    drain();
    check("wo_reg0", 64'(s_mem[0]), 64'(32'hDEADBEEF));
    check("wo_reg1", 64'(s_mem[1]), 64'(32'h11112222));

    // Throughput: four commands offered continuously, accepted every 4 cycles.
    acc_q.delete();
    run_cmd(1'b0, 32'h0C, 32'hCAFEF00D, 4'hF, model(1'b0, 32'h0C, 32'hCAFEF00D, 4'hF));
    run_cmd(1'b1, 32'h0C, 32'h0,        4'hF, model(1'b1, 32'h0C, 32'h0, 4'hF));
    run_cmd(1'b0, 32'h08, 32'h0F0F0F0F, 4'hF, model(1'b0, 32'h08, 32'h0F0F0F0F, 4'hF));
    run_cmd(1'b1, 32'h08, 32'h0,        4'hF, model(1'b1, 32'h08, 32'h0, 4'hF));
    drain();
    check("tp_accepts", 64'(acc_q.size()), 64'(4));
    if (acc_q.size() == 4)
      for (int i = 1; i < 4; i++) check("tp_spacing", 64'(acc_q[i] - acc_q[i-1]), 64'(4));

    // Response stall with a stray RdAck injected in RESP.
    rsp_ready = 1'b0;
    run_cmd(1'b1, 32'h08, 32'h0, 4'hF, model(1'b1, 32'h08, 32'h0, 4'hF));
    cmd_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin tick(); n++; end
      check("stall_rsp_seen", 64'(rsp_valid), 64'(1));
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", 64'(rsp_valid), 64'(1));
      check("stall_data", 64'(rsp_data), 64'(32'h0F0F0F0F));
      check("stall_cmd_ready", 64'(cmd_ready), 64'(0));
      if (i == 3) begin inj_rd = 1'b1; inj_data = 32'h0BAD0BAD; end
      if (i == 4) begin inj_rd = 1'b0; inj_data = '0; end
    end
    rsp_ready = 1'b1;
    drain();

    // Wrong-direction ack ignored, then matching RdAck carrying an error.
    slave_mute = 1'b1;
    run_cmd(1'b1, 32'h08, 32'h0, 4'hF, pack_exp(3, 4, 1'b0, 1'b1, 32'hFEEDF00D));
    cmd_valid = 1'b0;
    inj_wr = 1'b1;
    tick();
    inj_wr = 1'b0;
    check("wrack_ignored_cs", 64'(Bus2IP_CS), 64'(1));
    check("wrack_ignored_valid", 64'(rsp_valid), 64'(0));
    tick();
    inj_rd = 1'b1; inj_err = 1'b1; inj_data = 32'hFEEDF00D;
    tick();
    inj_rd = 1'b0; inj_err = 1'b0; inj_data = '0;
    slave_mute = 1'b0;
    drain();

    // Randomized traffic with random response back-pressure.
    bp_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic r;
          logic [AW-1:0] a;
          logic [DW-1:0] d;
          logic [3:0] be;
          r  = 1'($urandom_range(0, 1));
          a  = 32'($urandom_range(0, 8)) * 32'd4;
          d  = $urandom;
          be = 4'($urandom_range(0, 15));
          run_cmd(r, a, d, be, model(r, a, d, be));
        end
        cmd_valid = 1'b0;
        bp_en = 1'b0;
      end
      begin
        while (bp_en) begin tick(); rsp_ready = ($urandom_range(0, 3) != 0); end
        rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset pulse in the middle of an access: no response may follow.
    run_cmd(1'b1, 32'h00, 32'h0, 4'hF, pack_exp(255, 255, 1'b1, 1'b1, '0));
    cmd_valid = 1'b0;
    tick();
    exp_q.delete();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("midrst_cs", 64'(Bus2IP_CS), 64'(0));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("midrst_state", 64'(dbg_state), 64'(0));
    tick();
    check("midrst_ready_back", 64'(cmd_ready), 64'(1));
    for (int i = 0; i < 12; i++) tick();
    run_cmd(1'b1, 32'h0C, 32'h0, 4'hF, model(1'b1, 32'h0C, 32'h0, 4'hF));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ipif_cmd_initiator.md
# ipif_cmd_initiator

Bus-master side of the IPIF register interface. It accepts single register read/write commands on a valid/ready stream and drives one IPIF access at a time into an IPIF register slave. It waits for the matching ack or for a timeout, then returns data and status on a response stream. It sits between a host/command source and the pcore register slaves, so register sequencing and debug can run from hardware.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width of the IPIF data path
- C_S_AXI_ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 64, maximum cycles Bus2IP_CS is held without an ack; must be ≥2
- Bus2IP_Clk  in  1  single clock; every port is synchronous to it
- Bus2IP_Resetn  in  1  reset, synchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at the rising edge
- cmd_rnw  in  1  1 = read, 0 = write
- cmd_addr  in  C_S_AXI_ADDR_WIDTH  byte address
- cmd_data  in  C_S_AXI_DATA_WIDTH  write data, ignored for reads
- cmd_be  in  C_S_AXI_DATA_WIDTH/8  byte enables
- rsp_valid  out  1  response present; held until accepted
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  C_S_AXI_DATA_WIDTH  read data; 0 for writes and for timeouts
- rsp_error  out  1  IP2Bus_Error sampled with the ack, or timeout
- rsp_timeout  out  1  no ack within TIMEOUT_CYCLES
- Bus2IP_Addr  out  C_S_AXI_ADDR_WIDTH; Bus2IP_Data  out  C_S_AXI_DATA_WIDTH; Bus2IP_BE  out  C_S_AXI_DATA_WIDTH/8; Bus2IP_RNW  out  1; Bus2IP_CS  out  1  (all registered)
- IP2Bus_Data  in  C_S_AXI_DATA_WIDTH; IP2Bus_RdAck  in  1; IP2Bus_WrAck  in  1; IP2Bus_Error  in  1

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - cmd_ready=1.
  - On accept: register the command onto Bus2IP_Addr/Data/BE/RNW, set Bus2IP_CS=1, clear the timeout counter, go to ACCESS.
- ACCESS:
  - CS and the bus fields stay stable.
  - A matching ack ends the access: RdAck if RNW=1, WrAck if RNW=0. On it, capture rsp_data (IP2Bus_Data for reads, 0 for writes), set rsp_error=IP2Bus_Error and rsp_timeout=0. Clear CS and go to RESP.
  - An ack of the wrong direction is ignored.
  - Counter reaches TIMEOUT_CYCLES-1 with no matching ack: rsp_timeout=1, rsp_error=1, rsp_data=0. Clear CS and go to RESP.
  - An ack arriving in the expiry cycle wins over the timeout.
- RESP:
  - rsp_valid=1 with rsp_* held stable.
  - On rsp_ready, go to IDLE and clear rsp_valid.
- Acks seen in IDLE or RESP are ignored and discarded. This covers the trailing duplicate ack that a registered-ack slave issues one cycle after CS falls.
- Only one transaction is outstanding at a time.
- Counter width is log2(TIMEOUT_CYCLES)+1 bits, saturating, and only increments in ACCESS.

## Timing
- Reset values: all outputs 0, including cmd_ready while Bus2IP_Resetn=0. cmd_ready=1 from the first cycle after reset is released.
- With a command accepted at edge T:
  - Bus2IP_CS=1 from T+1.
  - A slave with a one-cycle registered ack gives an ack at T+2.
  - rsp_valid=1 at T+3 and CS=0 at T+3.
- Sustained throughput is 4 cycles per transaction when rsp_ready is held at 1.
- Timeout path: CS is high for exactly TIMEOUT_CYCLES cycles; rsp_valid is set the following cycle.
- rsp_valid stalls indefinitely while rsp_ready=0. No new command is accepted during the stall.
- Reset mid-transaction: the access is abandoned and no response is emitted. At the next edge CS=0, rsp_valid=0 and the state is IDLE.

## Structure
- Shared package ipif_pkg holds:
  - state encoding localparams (IDLE/ACCESS/RESP)
  - the log2 width function, shared with the register slave
  - the default TIMEOUT_CYCLES value
- One natural sub-module: ipif_timeout_ctr, a clear/enable/expire counter parameterised by TIMEOUT_CYCLES.

## Test plan
- Write 0xDEADBEEF to address 0x00 of an ipif_regs instance (2 WO, 2 RW, 2 RO) -> rsp_valid at T+3 with rsp_error=0 and rsp_data=0. wo_regs[31:0]=0xDEADBEEF.
- Read RW address 0x08 after writing 0x12345678 -> rsp_data=0x12345678, rsp_error=0. Back-to-back commands accepted every 4 cycles with rsp_ready=1.
- Read address 0x00 (a WO register, so the slave never acks) with TIMEOUT_CYCLES=8 -> CS high 8 cycles, then rsp_timeout=1, rsp_error=1, rsp_data=0.
- Hold rsp_ready=0 for 10 cycles after a read -> rsp_valid and rsp_data stay stable; cmd_ready=0; a stray RdAck pulse injected during the stall has no effect.
- Assert Bus2IP_Resetn=0 for one cycle while in ACCESS -> next cycle CS=0, rsp_valid=0, cmd_ready=0; cmd_ready=1 the cycle after release.
- Inject WrAck during a read access, then RdAck with IP2Bus_Error=1 -> WrAck ignored; response has rsp_error=1 and rsp_timeout=0.
